// File: rtl/crossbar_loader_pkg.sv
// Shared command op codes and sequencer state encoding for the crossbar loader.
package crossbar_loader_pkg;

   localparam int OP_W = 2;

   typedef enum logic [OP_W-1:0] {
      OP_CONNECT   = 2'd0,
      OP_CLEAR     = 2'd1,
      OP_CLEAR_ALL = 2'd2,
      OP_RSVD      = 2'd3
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SETUP = 2'd1,
      ST_HIGH  = 2'd2,
      ST_LOW   = 2'd3
   } state_e;

endpackage

// File: rtl/crossbar_loader_if.sv
// Command channel from the configuration master into the crossbar loader.
interface crossbar_loader_if #(
   parameter int W = 8
);
   logic         cmd_valid;
   logic         cmd_ready;
   logic [1:0]   cmd_op;
   logic [W-1:0] cmd_from;
   logic [W-1:0] cmd_to;

   modport master (output cmd_valid, output cmd_op, output cmd_from, output cmd_to,
                   input  cmd_ready);
   modport slave  (input  cmd_valid, input  cmd_op, input  cmd_from, input  cmd_to,
                   output cmd_ready);
endinterface

// File: rtl/crossbar_loader_fifo_sync.sv
// Synchronous first-word fall-through FIFO; push into a full FIFO is taken
// only when a pop happens on the same edge.
module fifo_sync #(
   parameter int W_DATA = 8,
   parameter int DEPTH  = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              push,
   input  logic [W_DATA-1:0] din,
   input  logic              pop,
   output logic [W_DATA-1:0] dout,
   output logic              full,
   output logic              empty
);
   localparam int AW = $clog2(DEPTH);

   logic [AW:0]       wr_ptr, rd_ptr;
   logic [W_DATA-1:0] mem [DEPTH];
   logic              wr_en, rd_en;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign rd_en = pop && !empty;
   assign wr_en = push && (!full || rd_en);
   assign dout  = mem[rd_ptr[AW-1:0]];

   // Pointer update; the extra MSB distinguishes full from empty.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage write; contents need no reset since empty masks them.
   always_ff @(posedge clock) begin
      if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/crossbar_loader.sv
// Crossbar configuration sequencer: buffers commands and drives from/to/put
// with a registered setup / put-high / put-low strobe per crossbar write.
//
// state | meaning
// IDLE  | waiting for a command at the FIFO head
// SETUP | addresses driven, put low
// HIGH  | put high, crossbar latches addresses
// LOW   | put low, crossbar commits; addresses still held
module crossbar_loader
   import crossbar_loader_pkg::*;
#(
   parameter int W     = 8,
   parameter int IN    = 8,
   parameter int OUT   = 8,
   parameter int DEPTH = 4
) (
   input  logic          clock,
   input  logic          reset,
   crossbar_loader_if.slave cmd,
   output logic [W-1:0]  xb_from,
   output logic [W-1:0]  xb_to,
   output logic          xb_put,
   output logic          busy,
   output logic          err
);
   localparam int DW = OP_W + 2 * W;
   localparam int CW = $clog2(OUT) + 1;
   localparam logic [CW-1:0] COL_LAST = CW'(OUT - 1);

   state_e         state_q, state_d;
   logic [DW-1:0]  fifo_din, fifo_dout;
   logic           fifo_full, fifo_empty, push, pop;
   logic           ready_en;
   op_e            head_op;
   logic [W-1:0]   head_from, head_to;
   logic           head_ok, col_more, take_cmd;
   logic [CW-1:0]  col_q, col_d;
   logic           clr_all_q, clr_all_d;
   logic [W-1:0]   from_d, to_d;
   logic           put_d, err_d;

   assign fifo_din      = {cmd.cmd_op, cmd.cmd_from, cmd.cmd_to};
   assign cmd.cmd_ready = ready_en && !fifo_full;
   assign push          = cmd.cmd_valid && cmd.cmd_ready;

   fifo_sync #(.W_DATA(DW), .DEPTH(DEPTH)) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (push),
      .din   (fifo_din),
      .pop   (pop),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign head_op   = op_e'(fifo_dout[DW-1 -: OP_W]);
   assign head_from = fifo_dout[2*W-1 -: W];
   assign head_to   = fifo_dout[W-1:0];
   assign col_more  = clr_all_q && (col_q < COL_LAST);
   assign take_cmd  = !fifo_empty && ((state_q == ST_IDLE) || (state_q == ST_LOW && !col_more));
   assign busy      = !fifo_empty || (state_q != ST_IDLE);

   // Head-of-FIFO validation against the crossbar dimensions.
   always_comb begin
      head_ok = 1'b0;
      case (head_op)
         OP_CONNECT:   head_ok = (head_from < W'(IN)) && (head_to < W'(OUT));
         OP_CLEAR:     head_ok = (head_to < W'(OUT));
         OP_CLEAR_ALL: head_ok = 1'b1;
         default:      head_ok = 1'b0;
      endcase
   end

   // State register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // Next-state decode.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (!fifo_empty) state_d = head_ok ? ST_SETUP : ST_IDLE;
         ST_SETUP: state_d = ST_HIGH;
         ST_HIGH:  state_d = ST_LOW;
         ST_LOW: begin
            if (col_more)         state_d = ST_SETUP;
            else if (!fifo_empty) state_d = head_ok ? ST_SETUP : ST_IDLE;
            else                  state_d = ST_IDLE;
         end
         default:  state_d = ST_IDLE;
      endcase
   end

   // Next values of the registered crossbar port, column walk and FIFO pop.
   always_comb begin
      from_d    = xb_from;
      to_d      = xb_to;
      col_d     = col_q;
      clr_all_d = clr_all_q;
      put_d     = (state_q == ST_SETUP);
      err_d     = 1'b0;
      pop       = 1'b0;
      if (state_q == ST_LOW && col_more) begin
         col_d = col_q + 1'b1;
         to_d  = W'(col_d);
      end else if (take_cmd) begin
         pop = 1'b1;
         if (head_ok) begin
            clr_all_d = (head_op == OP_CLEAR_ALL);
            col_d     = '0;
            from_d    = (head_op == OP_CONNECT) ? head_from : '1;
            to_d      = (head_op == OP_CLEAR_ALL) ? '0 : head_to;
         end else begin
            err_d = 1'b1;
         end
      end
   end

   // Output and datapath registers; put drops immediately on reset.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         xb_from   <= '1;
         xb_to     <= '0;
         xb_put    <= 1'b0;
         err       <= 1'b0;
         col_q     <= '0;
         clr_all_q <= 1'b0;
         ready_en  <= 1'b0;
      end else begin
         xb_from   <= from_d;
         xb_to     <= to_d;
         xb_put    <= put_d;
         err       <= err_d;
         col_q     <= col_d;
         clr_all_q <= clr_all_d;
         ready_en  <= 1'b1;
      end
   end

endmodule

// File: tb/tb_crossbar_loader.sv
// Directed bench for crossbar_loader with a behavioural 8x8 crossbar model.
module tb_crossbar_loader;
   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] xb_from, xb_to;
   logic       xb_put, busy, err;

   crossbar_loader_if #(.W(8)) cmd_if ();

   crossbar_loader #(.W(8), .IN(8), .OUT(8), .DEPTH(4)) dut (
      .clock   (clock),
      .reset   (reset),
      .cmd     (cmd_if),
      .xb_from (xb_from),
      .xb_to   (xb_to),
      .xb_put  (xb_put),
      .busy    (busy),
      .err     (err)
   );

   always #5 clock = ~clock;

   int compared = 0;
   int mismatched = 0;
   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   // crossbar model: latch on put rise, commit on put fall
   logic signed [7:0] conn [8];
   logic [7:0] la_from, la_to;
   logic [7:0] in_vals [8];
   initial for (int i = 0; i < 8; i++) in_vals[i] = 8'h10 + 8'(i);
   always @(posedge xb_put) begin la_from = xb_from; la_to = xb_to; end
   always @(negedge xb_put) if (!reset && la_to < 8) conn[la_to[2:0]] = la_from;
   always @(posedge reset) for (int i = 0; i < 8; i++) conn[i] = -8'sd1;

   function automatic logic [7:0] xb_out(input int j);
      logic signed [7:0] c;
      c = conn[j];
      return (c == -8'sd1) ? 8'h00 : in_vals[c[2:0]];
   endfunction

   // put log plus strobe/address invariants
   int         put_cyc [$];
   logic [7:0] put_from [$];
   logic [7:0] put_to [$];
   int         err_cnt = 0;
   logic       prev_put = 1'b0, prev_err = 1'b0, saw_full = 1'b0;
   logic [7:0] prev_from = 8'h00, prev_to = 8'h00;

   always @(negedge clock) begin
      if (!reset) begin
         if (xb_put === 1'b1) begin
            put_cyc.push_back(cyc); put_from.push_back(xb_from); put_to.push_back(xb_to);
         end
         if (err === 1'b1) begin
            err_cnt++;
            compared++;
            if (prev_err) begin
               mismatched++;
               $display("FAIL err_width: err high two cycles running at cycle %0d, required single cycle", cyc);
            end
         end
         if (xb_put === 1'b1 || prev_put) begin
            compared++;
            if ((xb_put === 1'b1 && prev_put) || xb_from !== prev_from || xb_to !== prev_to) begin
               mismatched++;
               $display("FAIL strobe_inv: cycle %0d put=%b prev_put=%b from=%h/%h to=%h/%h, required no double put and stable addresses",
                        cyc, xb_put, prev_put, xb_from, prev_from, xb_to, prev_to);
            end
         end
      end
      prev_put  = (xb_put === 1'b1) && !reset;
      prev_err  = (err === 1'b1) && !reset;
      prev_from = xb_from;
      prev_to   = xb_to;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, required finish");
      $fatal(1, "timeout");
   end

   task automatic clear_log();
      put_cyc.delete(); put_from.delete(); put_to.delete();
      err_cnt = 0;
   endtask

   // Offer one command starting at a negedge; returns at the negedge after acceptance.
   task automatic send(input logic [1:0] op, input logic [7:0] f, input logic [7:0] t);
      int budget = 50;
      cmd_if.cmd_valid = 1'b1; cmd_if.cmd_op = op; cmd_if.cmd_from = f; cmd_if.cmd_to = t;
      while (!cmd_if.cmd_ready && budget > 0) begin
         saw_full = 1'b1;
         @(negedge clock);
         budget--;
      end
      if (budget == 0) begin
         compared++; mismatched++;
         $display("FAIL send_timeout: cmd_ready=%b after 50 cycles, required 1", cmd_if.cmd_ready);
      end else begin
         @(posedge clock);
         @(negedge clock);
      end
      cmd_if.cmd_valid = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while (busy !== 1'b0 && n < budget) begin @(negedge clock); n++; end
      compared++;
      if (busy !== 1'b0) begin
         mismatched++;
         $display("FAIL idle_timeout: busy=%b after %0d cycles, required 0", busy, budget);
      end
   endtask

   task automatic test_reset();
      @(negedge clock);
      #2 reset = 1'b1;
      #1;
      compared++; if (xb_put !== 1'b0) begin mismatched++; $display("FAIL rst_put: got %b want 0", xb_put); end
      compared++; if (xb_from !== 8'hFF) begin mismatched++; $display("FAIL rst_from: got %h want ff", xb_from); end
      compared++; if (xb_to !== 8'h00) begin mismatched++; $display("FAIL rst_to: got %h want 00", xb_to); end
      compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL rst_busy: got %b want 0", busy); end
      compared++; if (err !== 1'b0) begin mismatched++; $display("FAIL rst_err: got %b want 0", err); end
      @(negedge clock);
      reset = 1'b0;
      @(posedge clock); #1;
      compared++; if (cmd_if.cmd_ready !== 1'b1) begin mismatched++; $display("FAIL rst_ready: got %b want 1", cmd_if.cmd_ready); end
      @(negedge clock);
   endtask

   // Single CONNECT from an empty/idle loader, checked cycle by cycle.
   task automatic test_connect(input logic [7:0] f, input logic [7:0] t);
      cmd_if.cmd_valid = 1'b1; cmd_if.cmd_op = 2'd0; cmd_if.cmd_from = f; cmd_if.cmd_to = t;
      @(posedge clock);            // edge N
      @(negedge clock);
      cmd_if.cmd_valid = 1'b0;
      compared++; if (xb_put !== 1'b0 || busy !== 1'b1) begin mismatched++; $display("FAIL conn_n0: put=%b busy=%b want put=0 busy=1", xb_put, busy); end
      @(negedge clock);            // after N+1
      compared++; if (xb_from !== f || xb_to !== t || xb_put !== 1'b0) begin mismatched++; $display("FAIL conn_n1: from=%h to=%h put=%b want from=%h to=%h put=0", xb_from, xb_to, xb_put, f, t); end
      @(negedge clock);            // after N+2
      compared++; if (xb_put !== 1'b1) begin mismatched++; $display("FAIL conn_n2: put=%b want 1", xb_put); end
      @(negedge clock);            // after N+3
      compared++; if (xb_put !== 1'b0 || busy !== 1'b1) begin mismatched++; $display("FAIL conn_n3: put=%b busy=%b want put=0 busy=1", xb_put, busy); end
      @(negedge clock);            // after N+4
      compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL conn_n4: busy=%b want 0", busy); end
      compared++; if (conn[t[2:0]] !== f || xb_out(t) !== in_vals[f[2:0]]) begin mismatched++; $display("FAIL conn_model: conn[%0d]=%h out=%h want %h / %h", t, conn[t[2:0]], xb_out(t), f, in_vals[f[2:0]]); end
   endtask

   task automatic test_clear_all();
      send(2'd0, 8'd1, 8'd0);
      send(2'd0, 8'd2, 8'd6);
      send(2'd0, 8'd7, 8'd7);
      wait_idle(40);
      compared++; if (conn[0] !== 8'sd1 || conn[6] !== 8'sd2 || conn[7] !== 8'sd7) begin mismatched++; $display("FAIL ca_pre: conn0=%h conn6=%h conn7=%h want 01 02 07", conn[0], conn[6], conn[7]); end
      clear_log();
      send(2'd2, 8'd0, 8'd0);
      wait_idle(60);
      compared++; if (put_cyc.size() != 8) begin mismatched++; $display("FAIL ca_count: got %0d puts want 8", put_cyc.size()); end
      for (int i = 0; i < 8 && i < put_cyc.size(); i++) begin
         compared++;
         if (put_from[i] !== 8'hFF || put_to[i] !== 8'(i) || (i > 0 && put_cyc[i] - put_cyc[i-1] != 3)) begin
            mismatched++;
            $display("FAIL ca_put%0d: from=%h to=%h cyc=%0d want from=ff to=%0d spacing 3", i, put_from[i], put_to[i], put_cyc[i], i);
         end
      end
      for (int j = 0; j < 8; j++) begin
         compared++; if (xb_out(j) !== 8'h00) begin mismatched++; $display("FAIL ca_out%0d: got %h want 00", j, xb_out(j)); end
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] fs [6];
      logic [7:0] ts [6];
      fs = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
      ts = '{8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2};
      clear_log();
      for (int i = 0; i < 6; i++) send(2'd0, fs[i], ts[i]);
      compared++; if (cmd_if.cmd_ready !== 1'b0) begin mismatched++; $display("FAIL b2b_full: cmd_ready=%b with 4 queued, want 0", cmd_if.cmd_ready); end
      wait_idle(60);
      compared++; if (put_cyc.size() != 6) begin mismatched++; $display("FAIL b2b_count: got %0d puts want 6", put_cyc.size()); end
      for (int i = 0; i < 6 && i < put_cyc.size(); i++) begin
         compared++;
         if (put_from[i] !== fs[i] || put_to[i] !== ts[i] || (i > 0 && put_cyc[i] - put_cyc[i-1] != 3) || conn[ts[i][2:0]] !== fs[i]) begin
            mismatched++;
            $display("FAIL b2b_put%0d: from=%h to=%h cyc=%0d want from=%h to=%h spacing 3", i, put_from[i], put_to[i], put_cyc[i], fs[i], ts[i]);
         end
      end
   endtask

   task automatic test_errors();
      clear_log();
      send(2'd0, 8'd8, 8'd0);
      repeat (3) @(negedge clock);
      send(2'd3, 8'd0, 8'd0);
      repeat (3) @(negedge clock);
      send(2'd0, 8'd1, 8'd2);
      wait_idle(20);
      repeat (3) @(negedge clock);
      compared++; if (err_cnt != 2) begin mismatched++; $display("FAIL err_count: got %0d err cycles want 2", err_cnt); end
      compared++; if (put_cyc.size() != 1) begin mismatched++; $display("FAIL err_puts: got %0d puts want 1", put_cyc.size()); end
      if (put_cyc.size() == 1) begin
         compared++; if (put_from[0] !== 8'd1 || put_to[0] !== 8'd2) begin mismatched++; $display("FAIL err_valid: from=%h to=%h want 01 02", put_from[0], put_to[0]); end
      end
   endtask

   task automatic test_reset_mid();
      int n = 0;
      cmd_if.cmd_valid = 1'b1; cmd_if.cmd_op = 2'd2; cmd_if.cmd_from = 8'd0; cmd_if.cmd_to = 8'd0;
      @(posedge clock); @(negedge clock);
      cmd_if.cmd_valid = 1'b0;
      while (xb_put !== 1'b1 && n < 20) begin @(negedge clock); n++; end
      compared++; if (xb_put !== 1'b1) begin mismatched++; $display("FAIL rm_high: put=%b want 1 before reset", xb_put); end
      #2 reset = 1'b1;
      #1;
      compared++; if (xb_put !== 1'b0 || busy !== 1'b0 || xb_from !== 8'hFF || xb_to !== 8'h00) begin
         mismatched++; $display("FAIL rm_async: put=%b busy=%b from=%h to=%h want 0 0 ff 00", xb_put, busy, xb_from, xb_to);
      end
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      compared++; if (cmd_if.cmd_ready !== 1'b1 || busy !== 1'b0) begin mismatched++; $display("FAIL rm_ready: ready=%b busy=%b want 1 0", cmd_if.cmd_ready, busy); end
      test_connect(8'd4, 8'd6);
   endtask

   initial begin
      cmd_if.cmd_valid = 1'b0; cmd_if.cmd_op = 2'd0; cmd_if.cmd_from = 8'd0; cmd_if.cmd_to = 8'd0;
      test_reset();
      test_connect(8'd3, 8'd5);
      test_clear_all();
      test_back_to_back();
      test_errors();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
